bus_ram: RTL and testbench

- Parametrised synchronous RAM for the 6502 machine bus; successor to the fixed 4 KiB monitor RAM.
- Width, depth and read latency are parameters; the bus can write and read.
- A boot-load port fills memory from a byte stream after reset, before the bus is served.
- Sits on the CPU bus behind the address decoder (ce); rdata is tristated onto the shared data bus.

---
 rtl/bus_ram.sv | 160 ++++++++++++++++
 tb/tb_bus_ram.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram.sv
// rtl/bus_ram.sv - parametrised 6502 bus RAM with boot-load port
//
// Purpose:
//   Synchronous RAM for the CPU bus, sitting behind the address decoder.
//   After reset it can sit in LOAD, filled from a byte stream, before it
//   starts serving the bus in RUN. Reads are pipelined with a fixed
//   READ_LATENCY. rdata is tristated onto the shared data bus.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   address, wdata, rw    bus address, write data, 1 = read / 0 = write
//   ce                    chip enable from the address decoder
//   rdata, rvalid         read data (high-Z unless rvalid) and its strobe
//   ld_valid, ld_data     boot-load byte stream
//   ld_last, ld_ready     final loader word marker; loader may transfer
//   loaded                high once the RAM is serving the bus
//   ld_overflow           sticky: loader wrapped the top address without ld_last
//   wp, wp_err            write-protect enable; pulse on a dropped write
//
// Optional feature macro: BUS_RAM_WPROT_EN
//   Defined: RUN writes with wp = 1 at address >= WP_BASE are dropped and
//   flagged on wp_err. Undefined: wp is ignored and wp_err stays 0.

module bus_ram #(
   parameter int          ADDR_WIDTH   = 12,
   parameter int          DATA_WIDTH   = 8,
   parameter int          READ_LATENCY = 1,
   parameter bit          BOOT_LOAD    = 1'b0,
   parameter string       INIT_FILE    = "",
   parameter int unsigned WP_BASE      = (ADDR_WIDTH > 8) ? (2**ADDR_WIDTH - 256) : 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rw,
   input  logic                  ce,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  loaded,
   output logic                  ld_overflow,
   input  logic                  wp,
   output logic                  wp_err
);

   localparam int                    DEPTH    = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

   typedef enum logic {S_LOAD, S_RUN} state_t;
   localparam state_t RESET_STATE = BOOT_LOAD ? S_LOAD : S_RUN;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ld_ptr_q, ld_ptr_d;
   logic                    ld_overflow_q, ld_overflow_d;
   logic                    wp_err_q, wp_err_d;
   logic [READ_LATENCY-1:0] rd_valid_q;
   logic [DATA_WIDTH-1:0]   rd_data_q [READ_LATENCY];

   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic                    rd_accept;
   logic                    wp_block;

`ifdef BUS_RAM_WPROT_EN
   assign wp_block = wp && (32'(address) >= WP_BASE);
`else
   logic unused_wp;
   assign unused_wp = wp;
   assign wp_block  = 1'b0;
`endif

   // Single write port shared between the loader (LOAD) and the bus (RUN).
   always_comb begin
      state_d       = state_q;
      ld_ptr_d      = ld_ptr_q;
      ld_overflow_d = ld_overflow_q;
      wp_err_d      = 1'b0;
      mem_we        = 1'b0;
      mem_waddr     = address;
      mem_wdata     = wdata;
      rd_accept     = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (ld_valid) begin
               mem_we    = 1'b1;
               mem_waddr = ld_ptr_q;
               mem_wdata = ld_data;
               ld_ptr_d  = ld_ptr_q + 1'b1;
               if (ld_last) begin
                  state_d = S_RUN;
               end else if (ld_ptr_q == TOP_ADDR) begin
                  // Stream ran past the top word: keep the data, flag it, stop loading.
                  ld_overflow_d = 1'b1;
                  state_d       = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (ce) begin
               if (rw) begin
                  rd_accept = 1'b1;
               end else if (wp_block) begin
                  wp_err_d = 1'b1;
               end else begin
                  mem_we = 1'b1;
               end
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RESET_STATE;
         ld_ptr_q      <= '0;
         ld_overflow_q <= 1'b0;
         wp_err_q      <= 1'b0;
         rd_valid_q    <= '0;
      end else begin
         state_q       <= state_d;
         ld_ptr_q      <= ld_ptr_d;
         ld_overflow_q <= ld_overflow_d;
         wp_err_q      <= wp_err_d;
         rd_valid_q    <= (rd_valid_q << 1) | READ_LATENCY'(rd_accept);
      end
   end

   // Memory is deliberately not reset; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Data stages carry no reset; the valid bits above decide what is visible.
   always_ff @(posedge clk) begin
      if (rd_accept) begin
         rd_data_q[0] <= mem[address];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
         rd_data_q[i] <= rd_data_q[i-1];
      end
   end

   assign rvalid      = rd_valid_q[READ_LATENCY-1];
   assign rdata       = rvalid ? rd_data_q[READ_LATENCY-1] : {DATA_WIDTH{1'bz}};
   assign ld_ready    = (state_q == S_LOAD);
   assign loaded      = (state_q == S_RUN);
   assign ld_overflow = ld_overflow_q;
   assign wp_err      = wp_err_q;

endmodule

// File: tb/tb_bus_ram.sv
// tb/tb_bus_ram.sv - self-checking bench for bus_ram (scoreboarded reads)

module tb_bus_ram;

`ifdef BUS_RAM_WPROT_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif
   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [11:0] address;
   logic [7:0] wdata;
   logic       rw, ce, ld_valid, ld_last, wp;
   logic [7:0] ld_data;
   wire  [7:0] rdata;
   logic       rvalid, ld_ready, loaded, ld_overflow, wp_err;

   logic [3:0] s_address;
   logic       s_rw, s_ce, s_ld_valid, s_ld_last, s_wp;
   logic [7:0] s_ld_data;
   wire  [7:0] s_rdata;
   logic       s_rvalid, s_ld_ready, s_loaded, s_ld_overflow, s_wp_err;

   always #5 clk = ~clk;

   bus_ram #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(LAT), .BOOT_LOAD(1'b1)) dut (
      .clk(clk), .reset(reset), .address(address), .wdata(wdata), .rw(rw), .ce(ce),
      .rdata(rdata), .rvalid(rvalid), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(ld_ready), .loaded(loaded),
      .ld_overflow(ld_overflow), .wp(wp), .wp_err(wp_err));

   bus_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(1), .BOOT_LOAD(1'b1)) dut_s (
      .clk(clk), .reset(reset), .address(s_address), .wdata(8'h00), .rw(s_rw), .ce(s_ce),
      .rdata(s_rdata), .rvalid(s_rvalid), .ld_valid(s_ld_valid), .ld_data(s_ld_data),
      .ld_last(s_ld_last), .ld_ready(s_ld_ready), .loaded(s_loaded),
      .ld_overflow(s_ld_overflow), .wp(s_wp), .wp_err(s_wp_err));

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] data;
      int         due;
   } rd_exp_t;
   rd_exp_t    sb_q[$];
   logic [7:0] model [4096];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: each rvalid must match the oldest outstanding read, on its due cycle.
   always @(negedge clk) begin
      if (rvalid) begin
         if (sb_q.size() == 0) begin
            check("rd_unexpected", 32'(sb_q.size()), 32'd1);
         end else begin
            rd_exp_t e;
            e = sb_q.pop_front();
            check("rd_data", {24'h0, rdata}, {24'h0, e.data});
            check("rd_cycle", cyc, e.due);
         end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
         check("rd_missing", {31'h0, rvalid}, 32'd1);
         void'(sb_q.pop_front());
      end
   end

   task automatic idle();
      @(negedge clk);
      ce = 1'b0; rw = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; wp = 1'b0;
   endtask

   task automatic ld_send(input logic [7:0] d, input logic last);
      @(negedge clk);
      ce = 1'b0; ld_valid = 1'b1; ld_data = d; ld_last = last;
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [7:0] d, input logic wpv);
      @(negedge clk);
      ld_valid = 1'b0; ce = 1'b1; rw = 1'b0; address = a; wdata = d; wp = wpv;
      if (!(WP_ON && wpv && a >= 12'hF00)) model[a] = d;
   endtask

   task automatic bus_read(input logic [11:0] a, input bit expect_data);
      @(negedge clk);
      ld_valid = 1'b0; ce = 1'b1; rw = 1'b1; address = a; wp = 1'b0;
      if (expect_data) sb_q.push_back('{data: model[a], due: cyc + LAT});
   endtask

   initial begin
      logic [7:0] ld_bytes [4];
      ld_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      reset = 1'b1; address = '0; wdata = '0; rw = 1'b1; ce = 1'b0; wp = 1'b0;
      ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
      s_address = '0; s_rw = 1'b1; s_ce = 1'b0; s_wp = 1'b0;
      s_ld_valid = 1'b0; s_ld_data = '0; s_ld_last = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ld_ready", {31'h0, ld_ready}, 32'd1);
      check("rst_loaded", {31'h0, loaded}, 32'd0);
      check("rst_rvalid", {31'h0, rvalid}, 32'd0);
      check("rst_overflow", {31'h0, ld_overflow}, 32'd0);
      check("rst_wp_err", {31'h0, wp_err}, 32'd0);
      reset = 1'b0;

      // Small RAM: 16 words without ld_last wraps the top address.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 15) begin
            check("s_ovf_before_top", {31'h0, s_ld_overflow}, 32'd0);
            check("s_ready_before_top", {31'h0, s_ld_ready}, 32'd1);
         end
         s_ld_valid = 1'b1; s_ld_data = 8'h80 + 8'(i);
      end
      @(negedge clk);
      check("s_overflow", {31'h0, s_ld_overflow}, 32'd1);
      check("s_loaded", {31'h0, s_loaded}, 32'd1);
      check("s_ready_run", {31'h0, s_ld_ready}, 32'd0);
      s_ld_data = 8'h55;
      @(negedge clk);
      s_ld_valid = 1'b0; s_ce = 1'b1; s_rw = 1'b1; s_address = 4'hF;
      @(negedge clk);
      check("s_rvalid_15", {31'h0, s_rvalid}, 32'd1);
      check("s_word15", {24'h0, s_rdata}, 32'h8F);
      s_address = 4'h0;
      @(negedge clk);
      check("s_word0_kept", {24'h0, s_rdata}, 32'h80);
      s_ce = 1'b0;
      @(negedge clk);
      check("s_rvalid_idle", {31'h0, s_rvalid}, 32'd0);

      // Main RAM: partial load with bus reads attempted in LOAD (ignored), then reset.
      for (int i = 0; i < 4; i++) begin
         ld_send(ld_bytes[i], 1'b0);
         ce = 1'b1; rw = 1'b1; address = 12'(i);
      end
      idle();
      reset = 1'b1;
      idle();
      reset = 1'b0;
      check("rst_mid_load_ready", {31'h0, ld_ready}, 32'd1);
      ld_send(8'hA9, 1'b0);
      ld_send(8'h42, 1'b0);
      ld_send(8'h85, 1'b1);
      idle();
      check("boot_loaded", {31'h0, loaded}, 32'd1);
      check("boot_ready_low", {31'h0, ld_ready}, 32'd0);
      check("boot_no_overflow", {31'h0, ld_overflow}, 32'd0);
      model[0] = 8'hA9; model[1] = 8'h42; model[2] = 8'h85; model[3] = 8'hEF;
      ld_send(8'h99, 1'b1);
      idle();

      for (int a = 0; a < 4; a++) bus_read(12'(a), 1'b1);
      idle();
      for (int a = 0; a < 3; a++) bus_write(12'h010 + 12'(a), 8'h31 + 8'(a), 1'b0);
      for (int a = 0; a < 3; a++) bus_read(12'h010 + 12'(a), 1'b1);
      idle();
      bus_write(12'h123, 8'h5A, 1'b0);
      bus_read(12'h123, 1'b1);
      idle();
      repeat (5) idle();

      // Read in flight when reset hits must never surface.
      bus_read(12'h011, 1'b0);
      idle();
      reset = 1'b1;
      idle();
      reset = 1'b0;
      check("rst_mid_read_ready", {31'h0, ld_ready}, 32'd1);
      repeat (4) idle();
      ld_send(8'hA9, 1'b1);
      idle();
      check("reload_loaded", {31'h0, loaded}, 32'd1);

      // Write protect around WP_BASE = 0xF00.
      bus_write(12'hEFF, 8'h01, 1'b0);
      bus_write(12'hF00, 8'h02, 1'b0);
      bus_write(12'hF00, 8'h77, 1'b1);
      idle();
      check("wp_err_pulse", {31'h0, wp_err}, {31'h0, WP_ON});
      idle();
      check("wp_err_clear", {31'h0, wp_err}, 32'd0);
      bus_write(12'hEFF, 8'h66, 1'b1);
      bus_read(12'hF00, 1'b1);
      bus_read(12'hEFF, 1'b1);
      bus_read(12'h000, 1'b1);
      idle();
      repeat (LAT + 3) idle();
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
